// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared widths and FSM state type for the rename rollback controller
package rename_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;
  localparam int AREG_W    = 6;
  localparam int PREG_W    = 7;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [AREG_W-1:0]    areg_t;
  typedef logic [PREG_W-1:0]    preg_t;

  typedef enum logic [1:0] {IDLE, WALK, DRAIN, DONE} rbk_state_t;
endpackage

// File: rtl/rename_rollback_ctrl_if.sv
// rtl/rename_rollback_ctrl_if.sv - flush, ROB read and rollback signals between controller and neighbours
interface rename_rollback_ctrl_if;
  import rename_pkg::*;

  logic     flush_req;
  rob_idx_t flush_rob_idx;
  rob_idx_t rob_tail;
  logic     flush_ready;
  rob_idx_t rob_rd_idx_0, rob_rd_idx_1;
  areg_t    rob_A_rd_0, rob_A_rd_1;
  preg_t    rob_P_rd_old_0, rob_P_rd_old_1;
  preg_t    rob_P_rd_new_0, rob_P_rd_new_1;
  logic     rollback_en_0, rollback_en_1;
  areg_t    rollback_A_rd_0, rollback_A_rd_1;
  preg_t    rollback_P_rd_old_0, rollback_P_rd_old_1;
  preg_t    rollback_P_rd_new_0, rollback_P_rd_new_1;
  logic     rename_stall;
  logic     rob_tail_we;
  rob_idx_t new_rob_tail;

  modport master (
    input  flush_req, flush_rob_idx, rob_tail,
    input  rob_A_rd_0, rob_A_rd_1, rob_P_rd_old_0, rob_P_rd_old_1,
    input  rob_P_rd_new_0, rob_P_rd_new_1,
    output flush_ready, rob_rd_idx_0, rob_rd_idx_1,
    output rollback_en_0, rollback_en_1, rollback_A_rd_0, rollback_A_rd_1,
    output rollback_P_rd_old_0, rollback_P_rd_old_1,
    output rollback_P_rd_new_0, rollback_P_rd_new_1,
    output rename_stall, rob_tail_we, new_rob_tail
  );

  modport slave (
    output flush_req, flush_rob_idx, rob_tail,
    output rob_A_rd_0, rob_A_rd_1, rob_P_rd_old_0, rob_P_rd_old_1,
    output rob_P_rd_new_0, rob_P_rd_new_1,
    input  flush_ready, rob_rd_idx_0, rob_rd_idx_1,
    input  rollback_en_0, rollback_en_1, rollback_A_rd_0, rollback_A_rd_1,
    input  rollback_P_rd_old_0, rollback_P_rd_old_1,
    input  rollback_P_rd_new_0, rollback_P_rd_new_1,
    input  rename_stall, rob_tail_we, new_rob_tail
  );
endinterface

// File: rtl/rename_rollback_ctrl.sv
// rtl/rename_rollback_ctrl.sv - walks squashed ROB entries youngest-first, two per cycle,
// driving rename rollback slots and finally reloading the ROB tail.
module rename_rollback_ctrl
  import rename_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  rename_rollback_ctrl_if.master bus
);

  rbk_state_t state_q, state_d;
  rob_idx_t   ptr_q, ptr_d;
  rob_idx_t   rem_q, rem_d;
  rob_idx_t   new_tail_q, new_tail_d;
  logic       en0_q, en0_d, en1_q, en1_d;
  areg_t      a0_q, a0_d, a1_q, a1_d;
  preg_t      old0_q, old0_d, old1_q, old1_d;
  preg_t      new0_q, new0_d, new1_q, new1_d;
  logic       tail_we_q, tail_we_d;

  rob_idx_t   cnt;
  rob_idx_t   n;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    new_tail_d = new_tail_q;
    en0_d      = 1'b0;
    en1_d      = 1'b0;
    a0_d       = a0_q;
    a1_d       = a1_q;
    old0_d     = old0_q;
    old1_d     = old1_q;
    new0_d     = new0_q;
    new1_d     = new1_q;
    tail_we_d  = 1'b0;
    cnt        = bus.rob_tail - bus.flush_rob_idx - ROB_IDX_W'(1);
    n          = (rem_q >= ROB_IDX_W'(2)) ? ROB_IDX_W'(2) : ROB_IDX_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          new_tail_d = bus.flush_rob_idx + ROB_IDX_W'(1);
          if (cnt == '0) begin
            state_d   = DONE;
            tail_we_d = 1'b1;
          end else begin
            ptr_d   = bus.rob_tail - ROB_IDX_W'(1);
            rem_d   = cnt;
            state_d = WALK;
          end
        end
      end
      WALK: begin
        // slot 0 carries the younger entry; rename lets slot 1 win RAT conflicts
        en0_d  = 1'b1;
        en1_d  = (n == ROB_IDX_W'(2));
        a0_d   = bus.rob_A_rd_0;
        a1_d   = bus.rob_A_rd_1;
        old0_d = bus.rob_P_rd_old_0;
        old1_d = bus.rob_P_rd_old_1;
        new0_d = bus.rob_P_rd_new_0;
        new1_d = bus.rob_P_rd_new_1;
        ptr_d  = ptr_q - n;
        rem_d  = rem_q - n;
        if (rem_q == n) state_d = DRAIN;
      end
      DRAIN: begin
        state_d   = DONE;
        tail_we_d = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      new_tail_q <= '0;
      en0_q      <= 1'b0;
      en1_q      <= 1'b0;
      a0_q       <= '0;
      a1_q       <= '0;
      old0_q     <= '0;
      old1_q     <= '0;
      new0_q     <= '0;
      new1_q     <= '0;
      tail_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      new_tail_q <= new_tail_d;
      en0_q      <= en0_d;
      en1_q      <= en1_d;
      a0_q       <= a0_d;
      a1_q       <= a1_d;
      old0_q     <= old0_d;
      old1_q     <= old1_d;
      new0_q     <= new0_d;
      new1_q     <= new1_d;
      tail_we_q  <= tail_we_d;
    end
  end

  assign bus.flush_ready         = (state_q == IDLE);
  assign bus.rename_stall        = (state_q != IDLE) | bus.flush_req;
  assign bus.rob_rd_idx_0        = ptr_q;
  assign bus.rob_rd_idx_1        = ptr_q - ROB_IDX_W'(1);
  assign bus.rollback_en_0       = en0_q;
  assign bus.rollback_en_1       = en1_q;
  assign bus.rollback_A_rd_0     = a0_q;
  assign bus.rollback_A_rd_1     = a1_q;
  assign bus.rollback_P_rd_old_0 = old0_q;
  assign bus.rollback_P_rd_old_1 = old1_q;
  assign bus.rollback_P_rd_new_0 = new0_q;
  assign bus.rollback_P_rd_new_1 = new1_q;
  assign bus.rob_tail_we         = tail_we_q;
  assign bus.new_rob_tail        = new_tail_q;

endmodule

// File: tb/tb_rename_rollback_ctrl.sv
// tb/tb_rename_rollback_ctrl.sv - directed self-checking bench for rename_rollback_ctrl
module tb_rename_rollback_ctrl;
  import rename_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  rename_rollback_ctrl_if bus();

  rename_rollback_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROB contents: A_rd = idx+1, P_old = idx+32, P_new = idx+64
  assign bus.rob_A_rd_0     = AREG_W'(bus.rob_rd_idx_0) + AREG_W'(1);
  assign bus.rob_A_rd_1     = AREG_W'(bus.rob_rd_idx_1) + AREG_W'(1);
  assign bus.rob_P_rd_old_0 = PREG_W'(bus.rob_rd_idx_0) + PREG_W'(32);
  assign bus.rob_P_rd_old_1 = PREG_W'(bus.rob_rd_idx_1) + PREG_W'(32);
  assign bus.rob_P_rd_new_0 = PREG_W'(bus.rob_rd_idx_0) + PREG_W'(64);
  assign bus.rob_P_rd_new_1 = PREG_W'(bus.rob_rd_idx_1) + PREG_W'(64);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ys/os: younger/older ROB index of each pair; two: whether slot 1 is valid
  task automatic run_flush(input int idx, input int tail, input int np,
                           input int ys[3], input int os[3], input bit two[3],
                           input int exp_tail, input bit hold);
    @(negedge clk);
    bus.flush_req     = 1'b1;
    bus.flush_rob_idx = ROB_IDX_W'(idx);
    bus.rob_tail      = ROB_IDX_W'(tail);
    #1;
    check("accept_ready", 32'(bus.flush_ready), 1);
    check("accept_stall", 32'(bus.rename_stall), 1);
    @(negedge clk);
    if (hold) begin
      bus.flush_rob_idx = 4'd7;
      bus.rob_tail      = 4'd8;
    end else begin
      bus.flush_req = 1'b0;
    end
    if (np > 0) begin
      check("walk_first_en0", 32'(bus.rollback_en_0), 0);
      check("walk_stall", 32'(bus.rename_stall), 1);
      @(negedge clk);
    end
    for (int k = 0; k < np; k++) begin
      check("pair_en0", 32'(bus.rollback_en_0), 1);
      check("pair_en1", 32'(bus.rollback_en_1), 32'(two[k]));
      check("pair_A0", 32'(bus.rollback_A_rd_0), 32'(ys[k] + 1));
      check("pair_old0", 32'(bus.rollback_P_rd_old_0), 32'(ys[k] + 32));
      check("pair_new0", 32'(bus.rollback_P_rd_new_0), 32'(ys[k] + 64));
      if (two[k]) begin
        check("pair_A1", 32'(bus.rollback_A_rd_1), 32'(os[k] + 1));
        check("pair_new1", 32'(bus.rollback_P_rd_new_1), 32'(os[k] + 64));
      end
      check("pair_ready", 32'(bus.flush_ready), 0);
      check("pair_tail_we", 32'(bus.rob_tail_we), 0);
      @(negedge clk);
    end
    check("done_tail_we", 32'(bus.rob_tail_we), 1);
    check("done_new_tail", 32'(bus.new_rob_tail), 32'(exp_tail));
    check("done_en0", 32'(bus.rollback_en_0), 0);
    check("done_en1", 32'(bus.rollback_en_1), 0);
    @(negedge clk);
    check("idle_tail_we", 32'(bus.rob_tail_we), 0);
    check("idle_ready", 32'(bus.flush_ready), 1);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst               = 1'b0;
    bus.flush_req     = 1'b0;
    bus.flush_rob_idx = '0;
    bus.rob_tail      = '0;
    repeat (2) @(negedge clk);
    check("rst_en0", 32'(bus.rollback_en_0), 0);
    check("rst_en1", 32'(bus.rollback_en_1), 0);
    check("rst_tail_we", 32'(bus.rob_tail_we), 0);
    check("rst_ready", 32'(bus.flush_ready), 1);
    check("rst_stall", 32'(bus.rename_stall), 0);
    check("rst_new_tail", 32'(bus.new_rob_tail), 0);
    rst = 1'b1;
    @(negedge clk);

    run_flush(5, 10, 2, '{9, 7, 0}, '{8, 6, 0}, '{1'b1, 1'b1, 1'b0}, 6, 1'b0);
    run_flush(2, 6, 2, '{5, 3, 0}, '{4, 2, 0}, '{1'b1, 1'b0, 1'b0}, 3, 1'b0);
    run_flush(14, 2, 2, '{1, 15, 0}, '{0, 14, 0}, '{1'b1, 1'b0, 1'b0}, 15, 1'b0);
    run_flush(7, 8, 0, '{0, 0, 0}, '{0, 0, 0}, '{1'b0, 1'b0, 1'b0}, 8, 1'b0);

    // second request held during the walk is taken right after DONE
    run_flush(5, 10, 2, '{9, 7, 0}, '{8, 6, 0}, '{1'b1, 1'b1, 1'b0}, 6, 1'b1);
    @(negedge clk);
    bus.flush_req = 1'b0;
    check("held_tail_we", 32'(bus.rob_tail_we), 1);
    check("held_new_tail", 32'(bus.new_rob_tail), 8);
    @(negedge clk);

    // asynchronous reset in the middle of a walk
    @(negedge clk);
    bus.flush_req     = 1'b1;
    bus.flush_rob_idx = 4'd2;
    bus.rob_tail      = 4'd6;
    @(negedge clk);
    bus.flush_req = 1'b0;
    @(negedge clk);
    check("mid_en0", 32'(bus.rollback_en_0), 1);
    check("mid_stall", 32'(bus.rename_stall), 1);
    #2 rst = 1'b0;
    #1;
    check("arst_en0", 32'(bus.rollback_en_0), 0);
    check("arst_en1", 32'(bus.rollback_en_1), 0);
    check("arst_tail_we", 32'(bus.rob_tail_we), 0);
    check("arst_stall", 32'(bus.rename_stall), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.flush_ready), 1);
    check("post_rst_en0", 32'(bus.rollback_en_0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
